line_feeder: RTL and testbench



---
 rtl/conv_pkg.sv | 13 +
 rtl/line_mem.sv | 24 ++
 rtl/line_feeder.sv | 81 ++++++++
 tb/tb_line_feeder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared defaults and word/stack types for the convolution engine image path.
package conv_pkg;

  localparam int IMAGE_WIDTH   = 16;
  localparam int IMAGE_NB      = 8;
  localparam int KERNEL_HEIGHT = 3;
  localparam int ROW_WORDS     = 4;
  localparam int WORD_WIDTH    = IMAGE_WIDTH * IMAGE_NB;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef word_t stack_t [KERNEL_HEIGHT];

endpackage

// File: rtl/line_mem.sv
// One image row of words: synchronous write, asynchronous read, one shared address.
module line_mem
  import conv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_feeder.sv
// Stacks each accepted word with the same column of the previous KERNEL_HEIGHT-1 rows.
// One cycle accept-to-valid; single output register, ready passes straight through.
module line_feeder
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH   = conv_pkg::IMAGE_WIDTH,
  parameter int IMAGE_NB      = conv_pkg::IMAGE_NB,
  parameter int KERNEL_HEIGHT = conv_pkg::KERNEL_HEIGHT,
  parameter int ROW_WORDS     = conv_pkg::ROW_WORDS,
  localparam int WORD_WIDTH   = IMAGE_WIDTH * IMAGE_NB
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WORD_WIDTH-1:0]             up_data,
  input  logic                              up_valid,
  input  logic                              up_last,
  output logic                              up_ready,
  output logic [KERNEL_HEIGHT*WORD_WIDTH-1:0] image,
  output logic                              image_valid,
  input  logic                              dn_ready,
  output logic                              frame_err
);

  localparam int CW = $clog2(ROW_WORDS);
  localparam int FW = $clog2(KERNEL_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(ROW_WORDS - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(KERNEL_HEIGHT - 1);

  logic [CW-1:0]         col;
  logic [FW-1:0]         fill;
  logic                  accept;
  logic [WORD_WIDTH-1:0] rd [KERNEL_HEIGHT-1];

  assign up_ready = !image_valid || dn_ready;
  assign accept   = up_valid && up_ready;

  // Rows shift one memory older per accept; the newest memory takes the incoming word.
  for (genvar k = 0; k < KERNEL_HEIGHT-1; k++) begin : g_mem
    logic [WORD_WIDTH-1:0] wd;
    if (k == KERNEL_HEIGHT-2) begin : g_top
      assign wd = up_data;
    end else begin : g_mid
      assign wd = rd[k+1];
    end
    line_mem #(.DEPTH(ROW_WORDS), .WIDTH(WORD_WIDTH)) u_mem (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (wd),
      .rdata (rd[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image       <= '0;
      image_valid <= 1'b0;
      frame_err   <= 1'b0;
      col         <= '0;
      fill        <= '0;
    end else begin
      if (accept) begin
        for (int h = 0; h < KERNEL_HEIGHT-1; h++) image[h*WORD_WIDTH +: WORD_WIDTH] <= rd[h];
        image[(KERNEL_HEIGHT-1)*WORD_WIDTH +: WORD_WIDTH] <= up_data;
        if (up_last) begin
          col  <= '0;
          fill <= '0;
          if (col != COL_LAST) frame_err <= 1'b1;
        end else if (col == COL_LAST) begin
          col <= '0;
          if (fill != FILL_FULL) fill <= fill + FW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (accept && fill == FILL_FULL) image_valid <= 1'b1;
      else if (dn_ready)               image_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_feeder.sv
// Directed scoreboard bench for line_feeder with 3-row stacks of 4-word rows of 16-bit words.
module tb_line_feeder;

  localparam int KH = 3;
  localparam int RW = 4;
  localparam int WW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [WW-1:0]   up_data = '0;
  logic            up_valid = 1'b0;
  logic            up_last = 1'b0;
  logic            up_ready;
  logic [KH*WW-1:0] image;
  logic            image_valid;
  logic            dn_ready = 1'b1;
  logic            frame_err;

  int checks = 0;
  int failures = 0;
  logic [KH*WW-1:0] exp_q [$];

  line_feeder #(
    .IMAGE_WIDTH(8), .IMAGE_NB(2), .KERNEL_HEIGHT(KH), .ROW_WORDS(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up_data(up_data), .up_valid(up_valid),
    .up_last(up_last), .up_ready(up_ready), .image(image),
    .image_valid(image_valid), .dn_ready(dn_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] wrd(input int r, input int c);
    logic [7:0] rr, cc;
    rr = r[7:0];
    cc = c[7:0];
    return {rr, cc};
  endfunction

  // Slice 0 (LSBs) is the oldest row, top slice is the current row.
  function automatic logic [KH*WW-1:0] stk(input int r, input int c);
    return {wrd(r, c), wrd(r-1, c), wrd(r-2, c)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every downstream handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && image_valid && dn_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stack_unexpected: got %0h expected none", image);
      end else begin
        logic [KH*WW-1:0] e;
        e = exp_q.pop_front();
        if (image !== e) begin
          failures++;
          $display("FAIL stack: got %0h expected %0h", image, e);
        end
      end
    end
  end

  task automatic send(input int r, input int c, input bit last);
    bit done;
    done = 1'b0;
    up_data  = wrd(r, c);
    up_last  = last;
    up_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (up_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: word %0h not accepted", wrd(r, c));
    end
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  // Sends one row; stacks are expected only once the previous rows are buffered.
  task automatic send_row(input int r, input bit emit, input bit last_at_end);
    for (int c = 0; c < RW; c++) begin
      if (emit) exp_q.push_back(stk(r, c));
      send(r, c, last_at_end && (c == RW-1));
    end
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_image_valid", 64'(image_valid), 64'd0);
    check("reset_up_ready", 64'(up_ready), 64'd1);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_image", 64'(image), 64'd0);
    check("idle_image_valid", 64'(image_valid), 64'd0);

    // Frame A: rows 0..3, backpressure held after stack at column 1 of row 2.
    send_row(0, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0);
    check("primed_no_output", 64'(image_valid), 64'd0);
    exp_q.push_back(stk(2, 0));
    send(2, 0, 1'b0);
    exp_q.push_back(stk(2, 1));
    send(2, 1, 1'b0);
    dn_ready = 1'b0;
    up_data  = wrd(2, 2);
    up_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_image_frozen", 64'(image), 64'({16'h0201, 16'h0101, 16'h0001}));
      check("bp_up_ready", 64'(up_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    dn_ready = 1'b1;
    exp_q.push_back(stk(2, 2));
    send(2, 2, 1'b0);
    exp_q.push_back(stk(2, 3));
    send(2, 3, 1'b0);
    send_row(3, 1'b1, 1'b1);
    drain("frameA_all_stacks");
    check("frameA_frame_err", 64'(frame_err), 64'd0);

    // Frame B: fresh priming, no stale rows from frame A.
    send_row(0, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0);
    send_row(2, 1'b1, 1'b1);
    drain("frameB_all_stacks");

    // Short frame ending at column 1 of row 1.
    send_row(0, 1'b0, 1'b0);
    send(1, 0, 1'b0);
    send(1, 1, 1'b1);
    #1;
    check("short_frame_err", 64'(frame_err), 64'd1);
    send_row(0, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0);
    send_row(2, 1'b1, 1'b1);
    drain("frameC_all_stacks");
    check("frame_err_sticky", 64'(frame_err), 64'd1);

    // Asynchronous reset mid-row 2 while a stack is held.
    send_row(0, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0);
    exp_q.push_back(stk(2, 0));
    send(2, 0, 1'b0);
    exp_q.push_back(stk(2, 1));
    send(2, 1, 1'b0);
    dn_ready = 1'b0;
    #2;
    check("held_before_reset", 64'(image_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_image_valid", 64'(image_valid), 64'd0);
    check("arst_up_ready", 64'(up_ready), 64'd1);
    check("arst_frame_err", 64'(frame_err), 64'd0);
    check("arst_image", 64'(image), 64'd0);
    check("arst_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    dn_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_row(0, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0);
    check("post_reset_primed", 64'(image_valid), 64'd0);
    send_row(2, 1'b1, 1'b0);
    send_row(3, 1'b1, 1'b1);
    drain("frameE_all_stacks");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
